// File: rtl/loop_fsm_ctrl.sv
// One-hot loop-controller FSM: start/finish handshake, BODY_STATES body states, DONE.
// Optional one-hot integrity check enabled by defining LOOP_FSM_ONEHOT_CHECK_EN.
module loop_fsm_ctrl #(
  parameter int BODY_STATES = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   fsm_stall,
  input  logic                   use_trip,
  input  logic [CNT_W-1:0]       trip_count,
  input  logic                   exit_cond,
  output logic [BODY_STATES+1:0] state_onehot,
  output logic                   busy,
  output logic                   finish,
  output logic [CNT_W-1:0]       iter_count,
  output logic                   state_err
);

  localparam int W = BODY_STATES + 2;
  localparam logic [W-1:0] IDLE_OH  = W'(1);
  localparam logic [W-1:0] FIRST_OH = IDLE_OH << 1;
  localparam logic [W-1:0] LAST_OH  = IDLE_OH << BODY_STATES;
  localparam logic [W-1:0] DONE_OH  = IDLE_OH << (BODY_STATES + 1);

  typedef enum logic [2:0] {
    PH_IDLE, PH_BODY, PH_LAST, PH_DONE, PH_BAD
  } phase_t;

  phase_t           phase;
  logic [W-1:0]     next_state;
  logic             mode_trip, mode_trip_nxt;
  logic [CNT_W-1:0] trip_q, trip_nxt;
  logic [CNT_W-1:0] iter_nxt, iter_inc;
  logic             finish_nxt;
  logic             iter_exit;
`ifdef LOOP_FSM_ONEHOT_CHECK_EN
  logic             err_q, err_nxt;
`endif

  assign busy     = ~state_onehot[0];
  assign iter_inc = iter_count + CNT_W'(1);

  always_comb begin
    // Decode the one-hot vector into a phase; anything unrecognised is illegal.
    phase = PH_BAD;
    case (state_onehot)
      IDLE_OH: phase = PH_IDLE;
      LAST_OH: phase = PH_LAST;
      DONE_OH: phase = PH_DONE;
      default: begin
        for (int k = 1; k < BODY_STATES; k++)
          if (state_onehot == (IDLE_OH << k)) phase = PH_BODY;
      end
    endcase

    next_state    = state_onehot;
    mode_trip_nxt = mode_trip;
    trip_nxt      = trip_q;
    iter_nxt      = iter_count;
    finish_nxt    = finish;
    iter_exit     = mode_trip ? (iter_inc == trip_q) : exit_cond;
`ifdef LOOP_FSM_ONEHOT_CHECK_EN
    err_nxt       = err_q;
`endif

    case (phase)
      PH_IDLE: begin
        finish_nxt = 1'b0;
        if (start && !fsm_stall) begin
          mode_trip_nxt = use_trip;
          trip_nxt      = trip_count;
          iter_nxt      = '0;
          next_state    = (use_trip && trip_count == '0) ? DONE_OH : FIRST_OH;
        end
      end
      PH_BODY: begin
        if (!fsm_stall) next_state = state_onehot << 1;
      end
      PH_LAST: begin
        if (!fsm_stall) begin
          // Saturating; in trip mode the exit compare stops it at trip_q anyway.
          if (iter_count != '1) iter_nxt = iter_inc;
          next_state = iter_exit ? DONE_OH : FIRST_OH;
        end
      end
      PH_DONE: begin
        finish_nxt = ~fsm_stall;
        if (!fsm_stall) next_state = IDLE_OH;
      end
      default: begin
`ifdef LOOP_FSM_ONEHOT_CHECK_EN
        next_state = IDLE_OH;
        err_nxt    = 1'b1;
        finish_nxt = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_onehot <= IDLE_OH;
      mode_trip    <= 1'b0;
      trip_q       <= '0;
      iter_count   <= '0;
      finish       <= 1'b0;
    end else begin
      state_onehot <= next_state;
      mode_trip    <= mode_trip_nxt;
      trip_q       <= trip_nxt;
      iter_count   <= iter_nxt;
      finish       <= finish_nxt;
    end
  end

`ifdef LOOP_FSM_ONEHOT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_nxt;
  end
  assign state_err = err_q;
`else
  assign state_err = 1'b0;
`endif

endmodule

// File: tb/tb_loop_fsm_ctrl.sv
// Directed self-checking bench for loop_fsm_ctrl (N=3, CNT_W=8).
module tb_loop_fsm_ctrl;
  logic       clk = 1'b0;
  logic       reset, start, fsm_stall, use_trip, exit_cond;
  logic [7:0] trip_count;
  logic [4:0] state_onehot;
  logic       busy, finish, state_err;
  logic [7:0] iter_count;
  int         checks = 0;
  int         failures = 0;

  localparam logic [4:0] IDLE = 5'b00001, S1 = 5'b00010, S2 = 5'b00100,
                         S3 = 5'b01000, DONE = 5'b10000;
  localparam logic [4:0] RUN2 [8] = '{S1, S2, S3, S1, S2, S3, DONE, IDLE};
  localparam logic [4:0] STALLRUN [8] = '{S1, S2, S2, S2, S3, DONE, IDLE, IDLE};

  loop_fsm_ctrl #(.BODY_STATES(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .fsm_stall(fsm_stall),
    .use_trip(use_trip), .trip_count(trip_count), .exit_cond(exit_cond),
    .state_onehot(state_onehot), .busy(busy), .finish(finish),
    .iter_count(iter_count), .state_err(state_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; fsm_stall = 1'b0; use_trip = 1'b0;
    exit_cond = 1'b0; trip_count = 8'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", state_onehot, IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_iter", iter_count, 8'd0);
    chk("rst_err", state_err, 1'b0);

    // Trip mode, trip_count=2; start accepted at edge 0.
    use_trip = 1'b1; trip_count = 8'd2; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("trip_state_c%0d", c), state_onehot, RUN2[c-1]);
      chk($sformatf("trip_finish_c%0d", c), finish, c == 8);
      if (c == 4) chk("trip_iter_c4", iter_count, 8'd1);
      if (c == 8) begin
        chk("trip_iter_end", iter_count, 8'd2);
        // Back-to-back: start in the finish cycle, exit_cond mode next.
        start = 1'b1; use_trip = 1'b0; trip_count = 8'd0;
      end
    end

    // Exit mode: exit_cond low in first S3, high in second S3.
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("exit_state_c%0d", c), state_onehot, RUN2[c-1]);
      chk($sformatf("exit_finish_c%0d", c), finish, c == 8);
      if (c == 1) chk("exit_iter_cleared", iter_count, 8'd0);
      if (c == 8) chk("exit_iter_end", iter_count, 8'd2);
      exit_cond = (c == 6);
    end
    exit_cond = 1'b0;
    tick();
    chk("exit_finish_after", finish, 1'b0);

    // Stall 2 cycles in S2 of a trip_count=1 run; start held high while busy.
    use_trip = 1'b1; trip_count = 8'd1; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("stall_state_c%0d", c), state_onehot, STALLRUN[c-1]);
      chk($sformatf("stall_finish_c%0d", c), finish, c == 7);
      if (c == 7) chk("stall_iter", iter_count, 8'd1);
      fsm_stall = (c == 2 || c == 3);
      if (c == 6) start = 1'b0;
    end

    // trip_count = 0: straight to DONE.
    trip_count = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("trip0_done", state_onehot, DONE);
    chk("trip0_finish_c1", finish, 1'b0);
    tick();
    chk("trip0_idle", state_onehot, IDLE);
    chk("trip0_finish_c2", finish, 1'b1);
    chk("trip0_iter", iter_count, 8'd0);

    // Stall held in DONE suppresses finish until released.
    start = 1'b1;
    tick(); start = 1'b0; fsm_stall = 1'b1;
    chk("dstall_done", state_onehot, DONE);
    tick();
    chk("dstall_hold_c2", state_onehot, DONE);
    chk("dstall_finish_c2", finish, 1'b0);
    tick(); fsm_stall = 1'b0;
    chk("dstall_hold_c3", state_onehot, DONE);
    chk("dstall_finish_c3", finish, 1'b0);
    tick();
    chk("dstall_idle", state_onehot, IDLE);
    chk("dstall_finish_c4", finish, 1'b1);
    tick();
    chk("dstall_finish_c5", finish, 1'b0);

    // Reset in the second S2 of a trip_count=3 run.
    trip_count = 8'd3; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    chk("mid_state_s2", state_onehot, S2);
    chk("mid_iter_pre", iter_count, 8'd1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("mid_rst_state", state_onehot, IDLE);
    chk("mid_rst_iter", iter_count, 8'd0);
    chk("mid_rst_finish", finish, 1'b0);
    tick();
    chk("mid_rst_nofinish", finish, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);

`ifdef LOOP_FSM_ONEHOT_CHECK_EN
    force dut.state_onehot = 5'b00110;
    @(negedge clk);
    release dut.state_onehot;
    tick();
    chk("chk_idle", state_onehot, IDLE);
    chk("chk_err", state_err, 1'b1);
    chk("chk_finish", finish, 1'b0);
    tick();
    chk("chk_err_sticky", state_err, 1'b1);
    chk("chk_finish2", finish, 1'b0);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("chk_err_rst", state_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
